// File: rtl/dcpu_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the dcpu memory bus.
// One transaction in flight at a time; a watchdog aborts transactions the slave never acknowledges.
module dcpu_bus_arbiter #(
    parameter int W       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic [W-1:0] i_m0_addr,
    input  logic [W-1:0] i_m0_dat,
    output logic [W-1:0] o_m0_dat,
    input  logic         i_m0_we,
    input  logic         i_m0_cs,
    output logic         o_m0_ack,
    output logic         o_m0_err,
    input  logic [W-1:0] i_m1_addr,
    input  logic [W-1:0] i_m1_dat,
    output logic [W-1:0] o_m1_dat,
    input  logic         i_m1_we,
    input  logic         i_m1_cs,
    output logic         o_m1_ack,
    output logic         o_m1_err,
    output logic [W-1:0] o_s_addr,
    output logic [W-1:0] o_s_dat,
    input  logic [W-1:0] i_s_dat,
    output logic         o_s_we,
    output logic         o_s_cs,
    input  logic         i_s_ack,
    output logic [1:0]   o_grant
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t        state, state_nxt;
    logic          r_last, last_nxt;
    logic [CW-1:0] r_cnt, cnt_nxt;

    logic          sel;
    logic          busy;
    logic          g_cs;
    logic          g_we;
    logic [W-1:0]  g_addr;
    logic [W-1:0]  g_dat;
    logic          timeout;
    logic          m_ack;
    logic [W-1:0]  m_dat;

    // Shared view of whichever master currently owns the bus.
    assign sel    = (state == BUSY1);
    assign busy   = (state != IDLE);
    assign g_cs   = sel ? i_m1_cs   : i_m0_cs;
    assign g_we   = sel ? i_m1_we   : i_m0_we;
    assign g_addr = sel ? i_m1_addr : i_m0_addr;
    assign g_dat  = sel ? i_m1_dat  : i_m0_dat;

    // A dropped request is an abort, not a timeout, so the watchdog only fires while cs is held.
    assign timeout = busy && g_cs && !i_s_ack && (r_cnt == CW'(TIMEOUT - 1));
    assign m_ack   = i_s_ack || timeout;
    assign m_dat   = timeout ? '0 : i_s_dat;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        last_nxt  = r_last;
        cnt_nxt   = '0;
        o_s_cs    = 1'b0;
        o_s_we    = 1'b0;
        o_s_addr  = '0;
        o_s_dat   = '0;
        o_grant   = 2'b00;
        o_m0_ack  = 1'b0;
        o_m0_err  = 1'b0;
        o_m0_dat  = '0;
        o_m1_ack  = 1'b0;
        o_m1_err  = 1'b0;
        o_m1_dat  = '0;

        case (state)
            IDLE: begin
                if (i_m0_cs && i_m1_cs) state_nxt = r_last ? BUSY0 : BUSY1;
                else if (i_m0_cs)       state_nxt = BUSY0;
                else if (i_m1_cs)       state_nxt = BUSY1;
            end
            BUSY0, BUSY1: begin
                o_s_cs   = g_cs && !timeout;
                o_s_we   = g_we;
                o_s_addr = g_addr;
                o_s_dat  = g_dat;
                o_grant  = sel ? 2'b10 : 2'b01;
                if (sel) begin
                    o_m1_ack = m_ack;
                    o_m1_err = timeout;
                    o_m1_dat = m_dat;
                end else begin
                    o_m0_ack = m_ack;
                    o_m0_err = timeout;
                    o_m0_dat = m_dat;
                end
                if (i_s_ack || !g_cs || timeout) begin
                    state_nxt = IDLE;
                    last_nxt  = sel;
                end else begin
                    cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            r_last <= 1'b1;
            r_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            r_last <= last_nxt;
            r_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Directed bench for dcpu_bus_arbiter: expected per-cycle bus views are queued as stimulus
// is applied and compared against the DUT outputs mid-cycle.
module tb_dcpu_bus_arbiter;

    typedef struct packed {
        logic [1:0]  grant;
        logic        s_cs;
        logic        s_we;
        logic [15:0] s_addr;
        logic [15:0] s_dat;
        logic        m0_ack;
        logic        m0_err;
        logic [15:0] m0_dat;
        logic        m1_ack;
        logic        m1_err;
        logic [15:0] m1_dat;
    } view_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] m0_addr = '0, m0_dat_w = '0, m1_addr = '0, m1_dat_w = '0, s_dat_r = '0;
    logic        m0_we = 1'b0, m0_cs = 1'b0, m1_we = 1'b0, m1_cs = 1'b0, s_ack = 1'b0;
    logic [15:0] m0_dat_r, m1_dat_r, s_addr, s_dat_w;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_we, s_cs;
    logic [1:0]  grant;

    view_t obs;
    view_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    dcpu_bus_arbiter #(.W(16), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_addr(m0_addr), .i_m0_dat(m0_dat_w), .o_m0_dat(m0_dat_r),
        .i_m0_we(m0_we), .i_m0_cs(m0_cs), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
        .i_m1_addr(m1_addr), .i_m1_dat(m1_dat_w), .o_m1_dat(m1_dat_r),
        .i_m1_we(m1_we), .i_m1_cs(m1_cs), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
        .o_s_addr(s_addr), .o_s_dat(s_dat_w), .i_s_dat(s_dat_r),
        .o_s_we(s_we), .o_s_cs(s_cs), .i_s_ack(s_ack), .o_grant(grant)
    );

    assign obs = '{grant, s_cs, s_we, s_addr, s_dat_w, m0_ack, m0_err, m0_dat_r, m1_ack, m1_err, m1_dat_r};

    function automatic view_t idle_v();
        return '0;
    endfunction

    // Expected view while master n owns the bus.
    function automatic view_t busy_v(input logic n, input logic scs, input logic swe,
                                     input logic [15:0] addr, input logic [15:0] wdat,
                                     input logic ack, input logic err, input logic [15:0] rdat);
        view_t v = '0;
        v.grant  = n ? 2'b10 : 2'b01;
        v.s_cs   = scs;
        v.s_we   = swe;
        v.s_addr = addr;
        v.s_dat  = wdat;
        if (n) begin
            v.m1_ack = ack; v.m1_err = err; v.m1_dat = rdat;
        end else begin
            v.m0_ack = ack; v.m0_err = err; v.m0_dat = rdat;
        end
        return v;
    endfunction

    task automatic expect_v(input view_t v);
        sb.push_back(v);
    endtask

    task automatic compare(input string tag);
        view_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: observed %h with no expected entry queued", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e)
            else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Compare mid-cycle, then move to just after the next rising edge.
    task automatic tick(input string tag);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic cs, input logic we, input logic [15:0] addr, input logic [15:0] dat);
        m0_cs = cs; m0_we = we; m0_addr = addr; m0_dat_w = dat;
    endtask

    task automatic set_m1(input logic cs, input logic we, input logic [15:0] addr, input logic [15:0] dat);
        m1_cs = cs; m1_we = we; m1_addr = addr; m1_dat_w = dat;
    endtask

    task automatic set_s(input logic ack, input logic [15:0] dat);
        s_ack = ack; s_dat_r = dat;
    endtask

    initial begin
        #1;
        expect_v(idle_v());
        compare("reset_state");
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read by m0, slave answers in the first BUSY cycle.
        set_m0(1, 0, 16'h0010, 16'h0000);
        expect_v(idle_v());
        tick("rd_idle");
        set_s(1, 16'hBEEF);
        expect_v(busy_v(0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'hBEEF));
        tick("rd_busy_ack");
        set_m0(0, 0, 16'h0000, 16'h0000);
        set_s(0, 16'h0000);
        expect_v(idle_v());
        tick("rd_back_idle");

        // Write by m1, slave acks on the third BUSY cycle.
        set_m1(1, 1, 16'h7FFF, 16'h1234);
        set_s(0, 16'h5555);
        expect_v(idle_v());
        tick("wr_idle");
        for (int i = 0; i < 2; i++) begin
            expect_v(busy_v(1, 1, 1, 16'h7FFF, 16'h1234, 0, 0, 16'h5555));
            tick("wr_busy_wait");
        end
        set_s(1, 16'h5555);
        expect_v(busy_v(1, 1, 1, 16'h7FFF, 16'h1234, 1, 0, 16'h5555));
        tick("wr_busy_ack");
        set_m1(0, 0, 16'h0000, 16'h0000);
        set_s(0, 16'h0000);
        expect_v(idle_v());
        tick("wr_back_idle");

        // Fresh reset, then both masters request continuously with an always-acking slave.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_m0(1, 0, 16'h00A0, 16'h0A0A);
        set_m1(1, 1, 16'h00B0, 16'h0B0B);
        set_s(1, 16'hCAFE);
        expect_v(idle_v());
        tick("rr_idle_late_ack");
        for (int i = 0; i < 7; i++) begin
            if (i % 4 == 0)
                expect_v(busy_v(0, 1, 0, 16'h00A0, 16'h0A0A, 1, 0, 16'hCAFE));
            else if (i % 4 == 2)
                expect_v(busy_v(1, 1, 1, 16'h00B0, 16'h0B0B, 1, 0, 16'hCAFE));
            else
                expect_v(idle_v());
            tick("rr_sequence");
        end
        set_m0(0, 0, 16'h0000, 16'h0000);
        set_m1(0, 0, 16'h0000, 16'h0000);
        set_s(0, 16'h0000);
        expect_v(idle_v());
        tick("rr_done_idle");

        // Watchdog: m0 requests and the slave never answers.
        set_m0(1, 0, 16'h0123, 16'h0000);
        set_s(0, 16'h9999);
        expect_v(idle_v());
        tick("to_idle");
        for (int i = 1; i < 15; i++) begin
            expect_v(busy_v(0, 1, 0, 16'h0123, 16'h0000, 0, 0, 16'h9999));
            tick("to_busy_wait");
        end
        expect_v(busy_v(0, 0, 0, 16'h0123, 16'h0000, 1, 1, 16'h0000));
        tick("to_fire");
        set_m0(0, 0, 16'h0000, 16'h0000);
        set_s(1, 16'h9999);
        expect_v(idle_v());
        tick("to_late_ack_ignored");
        set_s(0, 16'h0000);
        expect_v(idle_v());
        tick("to_back_idle");

        // Abort: m1 withdraws its request in its second BUSY cycle.
        set_m1(1, 0, 16'h0042, 16'h0000);
        expect_v(idle_v());
        tick("ab_idle");
        expect_v(busy_v(1, 1, 0, 16'h0042, 16'h0000, 0, 0, 16'h0000));
        tick("ab_busy");
        set_m1(0, 0, 16'h0042, 16'h0000);
        expect_v(busy_v(1, 0, 0, 16'h0042, 16'h0000, 0, 0, 16'h0000));
        tick("ab_drop_cs");
        set_m1(0, 0, 16'h0000, 16'h0000);
        expect_v(idle_v());
        tick("ab_back_idle");

        // Asynchronous reset in the middle of a BUSY0 transaction.
        set_m0(1, 0, 16'h0077, 16'h0000);
        expect_v(idle_v());
        tick("rst_req_idle");
        #2;
        expect_v(busy_v(0, 1, 0, 16'h0077, 16'h0000, 0, 0, 16'h0000));
        compare("rst_pre_busy");
        rst_n = 1'b0;
        #1;
        expect_v(idle_v());
        compare("rst_async_clear");
        @(posedge clk);
        #1;
        set_m1(1, 0, 16'h0088, 16'h0000);
        rst_n = 1'b1;
        expect_v(idle_v());
        tick("rst_release_idle");
        expect_v(busy_v(0, 1, 0, 16'h0077, 16'h0000, 0, 0, 16'h0000));
        tick("rst_m0_first");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcpu_bus_arbiter.md
Name: dcpu_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the dcpu memory bus (addr/dat/ack/we/cs handshake).
- Master 0 is the dcpu core; master 1 is a secondary requester (DMA/debug loader). The slave is the shared memory/IO bus.
- Round-robin arbitration, one outstanding transaction at a time, watchdog timeout so a dead slave cannot hang the core.

Parameters:
- W, 16, data and address width.
- TIMEOUT, 15, cycles in a BUSY state without i_s_ack before the transaction is aborted with error; legal range 1..255.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_m0_addr  in  W  master 0 address.
- i_m0_dat  in  W  master 0 write data.
- o_m0_dat  out  W  master 0 read data.
- i_m0_we  in  1  master 0 write enable.
- i_m0_cs  in  1  master 0 request.
- o_m0_ack  out  1  master 0 transfer done.
- o_m0_err  out  1  master 0 transfer timed out; valid with o_m0_ack.
- i_m1_addr, i_m1_dat, o_m1_dat, i_m1_we, i_m1_cs, o_m1_ack, o_m1_err: same as master 0, for master 1.
- o_s_addr  out  W  slave address.
- o_s_dat  out  W  slave write data.
- i_s_dat  in  W  slave read data.
- o_s_we  out  1  slave write enable.
- o_s_cs  out  1  slave select.
- i_s_ack  in  1  slave transfer done.
- o_grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 when idle.

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registers: state, r_last (last master served), r_cnt (timeout counter, clog2(TIMEOUT+1) bits).
- Reset (asynchronous, i_reset_n=0):
  - state=IDLE, r_last=1 (so m0 wins the first tie), r_cnt=0.
  - All outputs 0 immediately, since outputs decode combinationally from state.
- IDLE:
  - o_s_cs=0, o_s_we=0, o_s_addr=0, o_s_dat=0, o_grant=00.
  - m0 cs only -> BUSY0. m1 cs only -> BUSY1.
  - Both -> BUSY(the master that is not r_last). Neither -> stay IDLE.
  - r_cnt<=0 on every IDLE cycle.
- BUSYn:
  - o_s_cs=i_mn_cs, o_s_we=i_mn_we, o_s_addr=i_mn_addr, o_s_dat=i_mn_dat (combinational mux). o_grant=one-hot n.
  - o_mn_dat=i_s_dat and o_mn_ack=i_s_ack, combinational pass-through, same cycle.
  - The non-granted master sees ack=0, err=0, dat=0.
- Completion: i_s_ack=1 in BUSYn -> next state IDLE, r_last<=n.
  - One IDLE arbitration cycle always separates transactions.
  - Minimum latency, request-in-IDLE to ack: 1 cycle (cs in cycle 0, BUSY and slave ack in cycle 1).
- Abort: granted master drops cs in BUSYn without ack -> IDLE next cycle, r_last<=n, no ack generated.
- Timeout:
  - r_cnt increments each BUSY cycle without ack.
  - In the cycle where r_cnt==TIMEOUT-1 and i_s_ack=0: o_mn_ack=1, o_mn_err=1, o_mn_dat=0, o_s_cs=0.
  - Next state IDLE, r_last<=n.
  - i_s_ack and the timeout condition in the same cycle: ack wins, err=0.
- Late ack: i_s_ack while IDLE is ignored; no master sees it.
- o_mn_err is 0 in every cycle except the timeout cycle.
- Masters must hold addr/dat/we/cs stable from request until ack. Holding cs high after ack means a new request, which is arbitrated in the following IDLE cycle.
- Fairness: with both masters continuously requesting, grants alternate m0, m1, m0, ...; neither master waits more than one transaction.

Test Plan:
- Single read:
  - Stimulus: m0 cs=1, addr=0x0010, slave acks in cycle 1 with dat=0xBEEF.
  - Required: o_grant=01 in cycle 1; o_s_addr=0x0010, o_m0_ack=1, o_m0_dat=0xBEEF in cycle 1; IDLE in cycle 2.
- Write routing:
  - Stimulus: m1 cs=1, we=1, addr=0x7FFF, dat=0x1234; slave acks 3 cycles later.
  - Required: o_s_we=1 and o_s_dat=0x1234 throughout BUSY1; o_m1_ack pulses once; o_m0_ack stays 0.
- Tie and round-robin:
  - Stimulus: both cs held high after reset, slave acks immediately.
  - Required: grant sequence 01, 00, 10, 00, 01, 00, 10.
- Timeout:
  - Stimulus: m0 requests, slave never acks, TIMEOUT=15.
  - Required: o_m0_ack=1 and o_m0_err=1 in the 15th BUSY0 cycle; o_m0_dat=0; then IDLE; a later late i_s_ack is ignored.
- Abort and reset:
  - Abort: m1 drops cs in its 2nd BUSY1 cycle -> IDLE next cycle, no ack.
  - Reset: i_reset_n=0 mid-BUSY0 -> o_s_cs, o_grant, acks all 0 immediately, without a clock edge.
  - After reset release with both requesting: m0 granted first.
